// File: rtl/instr_mem_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : instr_mem_hs                                                     |
// | Brief   : Preloadable word-addressed instruction RAM with a valid/ready    |
// |           fetch handshake and a fixed read latency.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module instr_mem_hs #(
    parameter int              DATA_W    = 32,
    parameter int              ADDR_W    = 32,
    parameter int              DEPTH     = 64,
    parameter int              READ_LAT  = 2,
    parameter logic [DATA_W-1:0] NOP_INSTR = 'h38800000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_instr,
    output logic              resp_fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_err,
    output logic              busy
);

    localparam int                c_idx_w      = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] c_depth      = ADDR_W'(DEPTH);
    localparam int                c_cnt_w      = (READ_LAT > 2) ? $clog2(READ_LAT - 1) : 1;
    localparam int                c_cnt_init_i = (READ_LAT > 1) ? READ_LAT - 2 : 0;
    localparam logic [c_cnt_w-1:0] c_cnt_init  = c_cnt_w'(c_cnt_init_i);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_wait = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic               r_fault;
    logic [DATA_W-1:0]  r_instr;
    logic               r_resp_fault;
    logic               r_ld_err;
    logic [DATA_W-1:0]  r_mem [DEPTH];

    logic               w_idle;
    logic               w_accept;
    logic               w_req_fault;
    logic               w_ld_bad;
    logic               w_ld_write;
    logic               w_to_resp;
    logic [c_idx_w-1:0] w_req_idx;
    logic [c_idx_w-1:0] w_ld_idx;
    logic [c_idx_w-1:0] w_src_idx;
    logic               w_src_fault;

    // Full-width compare: upper address bits must not alias into the array.
    assign w_req_fault = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= c_depth);
    assign w_ld_bad    = (ld_addr[1:0]  != 2'b00) || ((ld_addr  >> 2) >= c_depth);
    assign w_req_idx   = req_addr[c_idx_w+1:2];
    assign w_ld_idx    = ld_addr[c_idx_w+1:2];

    assign w_idle      = (r_state == c_idle);
    assign w_accept    = req_valid && req_ready;
    assign w_ld_write  = ld_en && w_idle && !reset && !w_ld_bad;
    assign w_to_resp   = (w_next == c_resp) && (r_state != c_resp);
    // With READ_LAT=1 the request goes straight to RESP, so take its fields live.
    assign w_src_idx   = w_idle ? w_req_idx   : r_idx;
    assign w_src_fault = w_idle ? w_req_fault : r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_idle: if (w_accept) w_next = (READ_LAT > 1) ? c_wait : c_resp;
            c_wait: if (r_cnt == '0) w_next = c_resp;
            c_resp: if (resp_ready) w_next = c_idle;
            default: w_next = c_idle;
        endcase
    end

    always_comb begin
        req_ready  = w_idle && !ld_en && !reset;
        resp_valid = (r_state == c_resp);
        busy       = !w_idle;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_idx        <= '0;
            r_fault      <= 1'b0;
            r_instr      <= '0;
            r_resp_fault <= 1'b0;
            r_ld_err     <= 1'b0;
        end else begin
            r_ld_err <= ld_en && !(w_idle && !w_ld_bad);
            if (w_accept) begin
                r_idx   <= w_req_idx;
                r_fault <= w_req_fault;
                r_cnt   <= c_cnt_init;
            end else if ((r_state == c_wait) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_cnt_w'(1);
            end
            if (w_to_resp) begin
                r_instr      <= w_src_fault ? NOP_INSTR : r_mem[w_src_idx];
                r_resp_fault <= w_src_fault;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_write) begin
            r_mem[w_ld_idx] <= ld_data;
        end
    end

    assign resp_instr = r_instr;
    assign resp_fault = r_resp_fault;
    assign ld_err     = r_ld_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_hs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_instr_mem_hs                                                  |
// | Brief   : Scoreboard bench for instr_mem_hs: directed cases plus random    |
// |           loads/fetches against an array reference model.                 |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instr_mem_hs;

    localparam int          DW       = 32;
    localparam int          AW       = 32;
    localparam int          DEPTH    = 64;
    localparam int          READ_LAT = 2;
    localparam logic [31:0] NOP      = 32'h38800000;

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_instr;
    logic          resp_fault;
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          ld_err;
    logic          busy;

    instr_mem_hs #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(READ_LAT), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_fault(resp_fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_err(ld_err),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        fault;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mmem [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          popped_cyc = -1;
    bit          seen = 1'b0;
    bit          rand_rr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) if (rand_rr) resp_ready = ($urandom_range(0, 3) != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    // The block is idle unless a fetch is outstanding or its response leaves this cycle.
    function automatic bit model_busy();
        return (q.size() != 0) || (popped_cyc == cyc);
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       return {24'b0, 6'($urandom_range(0, 63)), 2'b00};
        else if (r == 7) return 32'($urandom_range(0, 255)) | 32'd1;
        else if (r == 8) return 32'h100 + 32'($urandom_range(0, 15)) * 4;
        else             return 32'hFFFF_FFFC;
    endfunction

    task automatic do_load(input logic [31:0] a, input logic [31:0] d);
        bit ok;
        @(negedge clk);
        req_valid = 1'b0; ld_en = 1'b1; ld_addr = a; ld_data = d;
        #2;
        ok = !model_busy() && !addr_bad(a);
        chk("req_ready_during_load", 32'(req_ready), 32'd0);
        if (ok) mmem[a[7:2]] = d;
        @(posedge clk); #1;
        chk("ld_err", 32'(ld_err), 32'(!ok));
        ld_en = 1'b0;
    endtask

    // req_valid/req_addr already driven; hold until the handshake happens.
    task automatic wait_accept(input logic [31:0] a);
        exp_t e;
        for (int n = 0; n < 60; n++) begin
            #2;
            chk("req_ready", 32'(req_ready), 32'(!model_busy() && !ld_en));
            if (req_ready) begin
                e.fault = addr_bad(a);
                e.instr = e.fault ? NOP : mmem[a[7:2]];
                e.acc   = cyc;
                q.push_back(e);
                @(posedge clk); #1;
                req_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: addr %h never accepted, expected accept within 60 cycles", a);
        req_valid = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        @(negedge clk);
        ld_en = 1'b0; req_valid = 1'b1; req_addr = a;
        wait_accept(a);
    endtask

    task automatic fetch_with_load(input logic [31:0] a, input logic [31:0] la, input logic [31:0] ld);
        bit ok;
        @(negedge clk);
        req_valid = 1'b1; req_addr = a; ld_en = 1'b1; ld_addr = la; ld_data = ld;
        #2;
        ok = !model_busy() && !addr_bad(la);
        chk("req_ready_load_wins", 32'(req_ready), 32'd0);
        if (ok) mmem[la[7:2]] = ld;
        @(posedge clk); #1;
        chk("ld_err_load_wins", 32'(ld_err), 32'(!ok));
        ld_en = 1'b0;
        @(negedge clk);
        wait_accept(a);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        forever begin
            @(negedge clk); #1;
            if (!reset && resp_valid) begin
                if (q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL resp_unexpected: resp_valid=1 instr %h, expected no response", resp_instr);
                end else begin
                    if (!seen) begin
                        chk("latency", 32'(cyc - q[0].acc), 32'(READ_LAT));
                        seen = 1'b1;
                    end
                    chk("resp_instr", resp_instr, q[0].instr);
                    chk("resp_fault", 32'(resp_fault), 32'(q[0].fault));
                    if (resp_ready) begin
                        void'(q.pop_front());
                        seen = 1'b0;
                        popped_cyc = cyc;
                    end
                end
            end
        end
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_instr", resp_instr, 32'd0);
        chk("rst_resp_fault", 32'(resp_fault), 32'd0);
        chk("rst_ld_err", 32'(ld_err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk); reset = 1'b0;
        #2;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < DEPTH; i++) do_load(32'(i * 4), $urandom);

        // Basic load then fetch, misaligned and out-of-range fetches.
        do_load(32'h0, 32'h58000001);
        do_load(32'h4, 32'h58080002);
        fetch(32'h4);
        fetch(32'h6);
        fetch(32'h100);
        fetch(32'hFC);
        do_load(32'h102, 32'hDEADBEEF);
        do_load(32'h100, 32'hDEADBEEF);

        // Consumer stall in RESP, then release.
        idle(4);
        resp_ready = 1'b0;
        fetch(32'h8);
        idle(7);
        resp_ready = 1'b1;
        fetch(32'hC);

        // Load and request in the same idle cycle.
        idle(4);
        fetch_with_load(32'h10, 32'h10, 32'hA5A5_0010);

        // Load while a fetch is in WAIT is rejected.
        idle(4);
        fetch(32'h0);
        do_load(32'h0, 32'h1234_5678);
        idle(4);
        fetch(32'h0);

        // Reset while in WAIT drops the fetch.
        idle(4);
        fetch(32'h4);
        @(negedge clk); reset = 1'b1;
        #2;
        chk("req_ready_in_reset", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        q.delete(); seen = 1'b0;
        chk("busy_after_reset", 32'(busy), 32'd0);
        chk("resp_valid_after_reset", 32'(resp_valid), 32'd0);
        @(negedge clk); reset = 1'b0;
        idle(3);
        fetch(32'h4);
        fetch(32'h0);

        // Random mix with a randomly stalling consumer.
        idle(4);
        rand_rr = 1'b1;
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 3)      do_load(rand_addr(), $urandom);
            else if (r < 9) fetch(rand_addr());
            else            idle($urandom_range(1, 4));
        end

        @(negedge clk);
        rand_rr = 1'b0;
        resp_ready = 1'b1;
        for (int n = 0; n < 100 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", q.size());
        end
        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
